// File: rtl/cpu_pkg.sv
// Shared CPU constants: register file defaults and the hard-wired zero register.
package cpu_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int NREGS_DEFAULT = 4;
    localparam int REG_ZERO      = 0;

    // Address width needed to index n registers.
    function automatic int reg_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Register scoreboard: tracks which registers await an outstanding result
// and arbitrates new destination reservations against pending ones.
//
// Reservation handshake: a reservation is accepted at a rising edge exactly
// when rsv_valid and rsv_ready are both 1. rsv_ready is combinational and does
// not depend on rsv_valid. When rsv_ready is 0 (WAW hazard) nothing changes
// and the requester keeps rsv_valid and rsv_reg stable until it is accepted.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int BYPASS = 1,
    localparam int AW    = reg_aw(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rr1,
    input  logic [AW-1:0]    rr2,
    input  logic             regwrite,
    input  logic [AW-1:0]    wr,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_reg,
    output logic             rsv_ready,
    output logic             busy1,
    output logic             busy2,
    output logic [NREGS-1:0] pending
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);
    localparam bit            FWD       = (BYPASS != 0);

    logic             wr_en;
    logic             rsv_take;
    logic [NREGS-1:0] pending_next;

    // Ready/busy decode and next scoreboard value; a set is applied after the
    // clear so a same-cycle reservation of the written register stays pending.
    always_comb begin
        wr_en     = regwrite && (wr != ZERO_ADDR);
        rsv_ready = (rsv_reg == ZERO_ADDR) || !pending[rsv_reg] ||
                    (regwrite && (wr == rsv_reg));
        rsv_take  = rsv_valid && rsv_ready && (rsv_reg != ZERO_ADDR);
        busy1     = pending[rr1] && !(FWD && wr_en && (wr == rr1));
        busy2     = pending[rr2] && !(FWD && wr_en && (wr == rr2));

        pending_next = pending;
        if (wr_en) begin
            pending_next[wr] = 1'b0;
        end
        if (rsv_take) begin
            pending_next[rsv_reg] = 1'b1;
        end
        pending_next[REG_ZERO] = 1'b0;
    end

    // Scoreboard flops; reset drops every outstanding reservation.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with optional write-to-read forwarding
// and a destination scoreboard for WAW hazard detection.
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int BYPASS = 1,
    localparam int AW    = reg_aw(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rr1,
    input  logic [AW-1:0]    rr2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             regwrite,
    input  logic [AW-1:0]    wr,
    input  logic [WIDTH-1:0] wd,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_reg,
    output logic             rsv_ready,
    output logic             busy1,
    output logic             busy2,
    output logic [NREGS-1:0] pending
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);
    localparam bit            FWD       = (BYPASS != 0);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_en;

    assign wr_en = regwrite && (wr != ZERO_ADDR);

    // Storage update; register 0 is never written so it stays at its reset zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr] <= wd;
        end
    end

    // Combinational reads with optional forwarding of the in-flight write.
    always_comb begin
        rd1 = (rr1 == ZERO_ADDR) ? '0 : regs[rr1];
        rd2 = (rr2 == ZERO_ADDR) ? '0 : regs[rr2];
        if (FWD && wr_en && (wr == rr1)) begin
            rd1 = wd;
        end
        if (FWD && wr_en && (wr == rr2)) begin
            rd2 = wd;
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .rr1       (rr1),
        .rr2       (rr2),
        .regwrite  (regwrite),
        .wr        (wr),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .rsv_ready (rsv_ready),
        .busy1     (busy1),
        .busy2     (busy2),
        .pending   (pending)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a vector table drives a forwarding and a
// non-forwarding 16x4 instance side by side; a 32x16 instance gets a sweep.
module tb_reg_file_sb;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic [1:0]  rr1 = '0, rr2 = '0, wr = '0, rsv_reg = '0;
    logic        regwrite = 1'b0, rsv_valid = 1'b0;
    logic [15:0] wd = '0;

    logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        rdy_a, rdy_b, b1_a, b2_a, b1_b, b2_b;
    logic [3:0]  pend_a, pend_b;

    logic        c_reset = 1'b1;
    logic [3:0]  c_rr1 = '0, c_rr2 = '0, c_wr = '0, c_rsv_reg = '0;
    logic        c_regwrite = 1'b0, c_rsv_valid = 1'b0;
    logic [31:0] c_wd = '0;
    logic [31:0] c_rd1, c_rd2;
    logic        c_rdy, c_b1, c_b2;
    logic [15:0] c_pend;

    reg_file_sb #(.WIDTH(16), .NREGS(4), .BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .rd1(rd1_a), .rd2(rd2_a),
        .regwrite(regwrite), .wr(wr), .wd(wd), .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .rsv_ready(rdy_a), .busy1(b1_a), .busy2(b2_a), .pending(pend_a)
    );

    reg_file_sb #(.WIDTH(16), .NREGS(4), .BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .rr1(rr1), .rr2(rr2), .rd1(rd1_b), .rd2(rd2_b),
        .regwrite(regwrite), .wr(wr), .wd(wd), .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .rsv_ready(rdy_b), .busy1(b1_b), .busy2(b2_b), .pending(pend_b)
    );

    reg_file_sb #(.WIDTH(32), .NREGS(16), .BYPASS(1)) dut_c (
        .clock(clock), .reset(c_reset), .rr1(c_rr1), .rr2(c_rr2), .rd1(c_rd1), .rd2(c_rd2),
        .regwrite(c_regwrite), .wr(c_wr), .wd(c_wd), .rsv_valid(c_rsv_valid), .rsv_reg(c_rsv_reg),
        .rsv_ready(c_rdy), .busy1(c_b1), .busy2(c_b2), .pending(c_pend)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [3:0]  exp_q[$];
    logic [31:0] exp_c_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  wr;
        logic [15:0] wd;
        logic [1:0]  rr1;
        logic [1:0]  rr2;
        logic        rv;
        logic [1:0]  rreg;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] rd1nb;
        logic [15:0] rd2nb;
        logic        rdy;
        logic        b1;
        logic        b2;
        logic        b1nb;
        logic        b2nb;
        logic [3:0]  pend;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    // ---------------- driver ----------------
    initial begin : main
        logic [3:0]  e;
        logic [31:0] ec;

        //            rst   we    wr    wd        rr1   rr2   rv    rreg  rd1       rd2       rd1nb     rd2nb     rdy   b1    b2    b1nb  b2nb  pend
        vec[0]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd2, 1'b0, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[1]  = '{1'b0, 1'b1, 2'd1, 16'h0007, 2'd0, 2'd3, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[2]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd0, 1'b0, 2'd0, 16'h0007, 16'h0000, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[3]  = '{1'b0, 1'b1, 2'd0, 16'hFFFF, 2'd0, 2'd0, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[4]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd1, 1'b0, 2'd0, 16'h0000, 16'h0007, 16'h0000, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[5]  = '{1'b0, 1'b1, 2'd2, 16'h1234, 2'd1, 2'd2, 1'b0, 2'd0, 16'h0007, 16'h1234, 16'h0007, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[6]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd2, 2'd2, 1'b0, 2'd0, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[7]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd3, 2'd2, 1'b1, 2'd3, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000};
        vec[8]  = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd3, 2'd0, 1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000};
        vec[9]  = '{1'b0, 1'b1, 2'd3, 16'h0005, 2'd3, 2'd3, 1'b0, 2'd0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
        vec[10] = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd3, 1'b1, 2'd1, 16'h0007, 16'h0005, 16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
        vec[11] = '{1'b0, 1'b1, 2'd1, 16'hBEEF, 2'd1, 2'd2, 1'b1, 2'd1, 16'hBEEF, 16'h1234, 16'h0007, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010};
        vec[12] = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd1, 1'b0, 2'd0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0010};
        vec[13] = '{1'b0, 1'b1, 2'd1, 16'h1111, 2'd2, 2'd1, 1'b1, 2'd2, 16'h1234, 16'h1111, 16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100};
        vec[14] = '{1'b0, 1'b1, 2'd1, 16'hAAAA, 2'd2, 2'd3, 1'b0, 2'd2, 16'h1234, 16'h0005, 16'h1234, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100};
        vec[15] = '{1'b1, 1'b1, 2'd3, 16'hFFFF, 2'd1, 2'd2, 1'b1, 2'd3, 16'hAAAA, 16'h1234, 16'hAAAA, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
        vec[16] = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd2, 1'b0, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[17] = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd3, 2'd3, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vec[18] = '{1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd0, 1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};

        repeat (2) @(posedge clock);

        for (int k = 0; k < NV; k++) begin
            @(negedge clock);
            reset     = vec[k].rst;
            regwrite  = vec[k].we;
            wr        = vec[k].wr;
            wd        = vec[k].wd;
            rr1       = vec[k].rr1;
            rr2       = vec[k].rr2;
            rsv_valid = vec[k].rv;
            rsv_reg   = vec[k].rreg;
            #1;
            chk($sformatf("v%0d rd1_a", k), 32'(rd1_a), 32'(vec[k].rd1));
            chk($sformatf("v%0d rd2_a", k), 32'(rd2_a), 32'(vec[k].rd2));
            chk($sformatf("v%0d rd1_b", k), 32'(rd1_b), 32'(vec[k].rd1nb));
            chk($sformatf("v%0d rd2_b", k), 32'(rd2_b), 32'(vec[k].rd2nb));
            chk($sformatf("v%0d rdy_a", k), 32'(rdy_a), 32'(vec[k].rdy));
            chk($sformatf("v%0d rdy_b", k), 32'(rdy_b), 32'(vec[k].rdy));
            chk($sformatf("v%0d busy1_a", k), 32'(b1_a), 32'(vec[k].b1));
            chk($sformatf("v%0d busy2_a", k), 32'(b2_a), 32'(vec[k].b2));
            chk($sformatf("v%0d busy1_b", k), 32'(b1_b), 32'(vec[k].b1nb));
            chk($sformatf("v%0d busy2_b", k), 32'(b2_b), 32'(vec[k].b2nb));
            exp_q.push_back(vec[k].pend);
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                chk($sformatf("v%0d queue", k), 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("v%0d pending_a", k), 32'(pend_a), 32'(e));
                chk($sformatf("v%0d pending_b", k), 32'(pend_b), 32'(e));
            end
        end

        @(negedge clock);
        regwrite  = 1'b0;
        rsv_valid = 1'b0;

        // ---------- 32x16 sweep: write every register with its address ----------
        c_reset = 1'b0;
        @(negedge clock);
        c_regwrite = 1'b1;
        c_wr       = 4'd0;
        c_wd       = 32'hDEADBEEF;
        for (int i = 1; i < 16; i++) begin
            @(negedge clock);
            c_wr = 4'(i);
            c_wd = 32'(i);
        end
        @(negedge clock);
        c_regwrite = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c_rr1 = 4'(i);
            c_rr2 = 4'(15 - i);
            exp_c_q.push_back(32'(i));
            exp_c_q.push_back(32'(15 - i));
            #1;
            ec = exp_c_q.pop_front();
            chk($sformatf("sweep rd1 r%0d", i), c_rd1, ec);
            ec = exp_c_q.pop_front();
            chk($sformatf("sweep rd2 r%0d", 15 - i), c_rd2, ec);
            @(negedge clock);
        end
        chk("sweep pending idle", 32'(c_pend), 32'h0);

        // ---------- reg15 reserve / clear round trip ----------
        c_rsv_valid = 1'b1;
        c_rsv_reg   = 4'd15;
        c_rr1       = 4'd15;
        #1;
        chk("r15 rsv_ready", 32'(c_rdy), 32'd1);
        chk("r15 busy before", 32'(c_b1), 32'd0);
        @(posedge clock);
        #1;
        chk("r15 pending set", 32'(c_pend), 32'h8000);
        chk("r15 rsv_ready held", 32'(c_rdy), 32'd0);
        @(negedge clock);
        c_rsv_valid = 1'b0;
        #1;
        chk("r15 busy1", 32'(c_b1), 32'd1);
        c_regwrite = 1'b1;
        c_wr       = 4'd15;
        c_wd       = 32'hCAFE0015;
        #1;
        chk("r15 busy1 forwarded", 32'(c_b1), 32'd0);
        chk("r15 rd1 forwarded", c_rd1, 32'hCAFE0015);
        @(posedge clock);
        #1;
        chk("r15 pending clear", 32'(c_pend), 32'h0);
        @(negedge clock);
        c_regwrite = 1'b0;
        #1;
        chk("r15 rd1 stored", c_rd1, 32'hCAFE0015);
        chk("r15 busy1 after", 32'(c_b1), 32'd0);

        // ---------- random same-cycle write/read forwarding on dut_c ----------
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            c_regwrite = 1'b1;
            c_wr       = 4'($urandom_range(1, 15));
            c_wd       = $urandom;
            c_rr2      = c_wr;
            exp_c_q.push_back(c_wd);
            #1;
            ec = exp_c_q.pop_front();
            chk($sformatf("rand fwd %0d", n), c_rd2, ec);
            exp_c_q.push_back(ec);
            @(negedge clock);
            c_regwrite = 1'b0;
            #1;
            ec = exp_c_q.pop_front();
            chk($sformatf("rand stored %0d", n), c_rd2, ec);
        end

        // ---------- final report ----------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
